// File: rtl/ram_dp_be.sv
// ram_dp_be: simple-dual-port synchronous RAM with a byte-enabled write port,
// an independent read port, selectable read-during-write behaviour, an
// optional output register and a sequential clear engine.
//
// The array is cleared one word per cycle through the normal write port
// rather than by a whole-array reset. This keeps the storage a plain
// single-write-port memory.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | normal operation; both ports serviced, clr_req accepted
// ST_CLEAR | writing zero to mem[r_clr_ptr] each cycle; ports ignored
module ram_dp_be #(
  parameter int DATA_W   = 32,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int SIZE     = 16,
  parameter int RDW_MODE = 0,
  parameter int READ_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr_req,
  output logic                       o_busy,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [DATA_W/BYTE_W-1:0]   i_wr_be,
  input  logic                       i_rd_en,
  input  logic [ADDR_W-1:0]          i_rd_addr,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_rd_valid
);

  localparam int NB = DATA_W / BYTE_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Last word touched by the clear engine, and SIZE widened by one bit so
  // that the range compare also works when SIZE == 2**ADDR_W.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);
  localparam logic [ADDR_W:0]   SIZE_EXT  = (ADDR_W + 1)'(SIZE);

  generate
    if ((DATA_W % BYTE_W) != 0) begin : g_bad_byte_w
      $error("ram_dp_be: DATA_W must be a multiple of BYTE_W");
    end
    if ((SIZE < 1) || (SIZE > (1 << ADDR_W))) begin : g_bad_size
      $error("ram_dp_be: SIZE must be in 1 .. 2**ADDR_W");
    end
    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_lat
      $error("ram_dp_be: READ_LAT must be 1 or 2");
    end
    if ((RDW_MODE != 0) && (RDW_MODE != 1)) begin : g_bad_rdw
      $error("ram_dp_be: RDW_MODE must be 0 or 1");
    end
  endgenerate

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DATA_W-1:0] r_mem [SIZE];

  logic [DATA_W-1:0] r_pipe_data;
  logic              r_pipe_valid;

  logic              w_idle;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_wr_fire;
  logic              w_rd_issue;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [NB-1:0]     w_mem_be;

  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_rd_merged;

  assign w_idle        = (r_state == ST_IDLE);
  assign w_wr_in_range = ({1'b0, i_wr_addr} < SIZE_EXT);
  assign w_rd_in_range = ({1'b0, i_rd_addr} < SIZE_EXT);
  assign w_wr_fire     = w_idle & i_wr_en & w_wr_in_range;
  assign w_rd_issue    = w_idle & i_rd_en;
  assign o_busy        = (r_state == ST_CLEAR);

  // Sequencer: reset or an accepted clr_req starts a full clear from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_clr_req) begin
        r_state   <= ST_CLEAR;
        r_clr_ptr <= '0;
      end
    end else begin
      if (r_clr_ptr == LAST_ADDR) begin
        r_state <= ST_IDLE;
      end else begin
        r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
      end
    end
  end

  // Single write port shared by the clear engine and the user write port.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = i_wr_addr;
    w_mem_data = i_wr_data;
    w_mem_be   = i_wr_be;
    if (r_state == ST_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_ptr;
      w_mem_data = '0;
      w_mem_be   = '1;
    end else if (w_wr_fire) begin
      w_mem_we = 1'b1;
    end
  end

  // Array write with per-lane enables; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (w_mem_be[k]) begin
          r_mem[w_mem_addr][k*BYTE_W +: BYTE_W] <= w_mem_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign w_rd_word = w_rd_in_range ? r_mem[i_rd_addr] : '0;

  // Write-first forwarding: overlay the enabled lanes of a same-address write.
  // A firing write is always in range, so a match implies an in-range read.
  always_comb begin
    w_rd_merged = w_rd_word;
    if ((RDW_MODE == 1) && w_wr_fire && (i_wr_addr == i_rd_addr)) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wr_be[k]) begin
          w_rd_merged[k*BYTE_W +: BYTE_W] = i_wr_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // First read register; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_data  <= '0;
      r_pipe_valid <= 1'b0;
    end else begin
      r_pipe_valid <= w_rd_issue;
      if (w_rd_issue) begin
        r_pipe_data <= w_rd_merged;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_out_data;
      logic              r_out_valid;

      // Extra output register; only valid results overwrite the held data.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= r_pipe_valid;
          if (r_pipe_valid) begin
            r_out_data <= r_pipe_data;
          end
        end
      end

      assign o_rd_data  = r_out_data;
      assign o_rd_valid = r_out_valid;
    end else begin : g_lat1
      assign o_rd_data  = r_pipe_data;
      assign o_rd_valid = r_pipe_valid;
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: three ram_dp_be instances driven by one stimulus stream.
//   dut0: SIZE=16, read-first,  READ_LAT=1
//   dut1: SIZE=16, write-first, READ_LAT=2
//   dut2: SIZE=12, read-first,  READ_LAT=1 (addresses 12..15 out of range)
// Each applied cycle pushes the expected read result per instance into a
// scoreboard queue; entries are popped when that instance's latency elapses.
module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        rst, clr, wr_en, rd_en;
  logic [3:0]  wa, ra, be;
  logic [31:0] wd;

  logic [31:0] o_d [3];
  logic        o_v [3];
  logic        o_b [3];

  always #5 clk = ~clk;

  ram_dp_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .SIZE(16), .RDW_MODE(0), .READ_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .i_clr_req(clr), .o_busy(o_b[0]),
    .i_wr_en(wr_en), .i_wr_addr(wa), .i_wr_data(wd), .i_wr_be(be),
    .i_rd_en(rd_en), .i_rd_addr(ra), .o_rd_data(o_d[0]), .o_rd_valid(o_v[0]));

  ram_dp_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .SIZE(16), .RDW_MODE(1), .READ_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .i_clr_req(clr), .o_busy(o_b[1]),
    .i_wr_en(wr_en), .i_wr_addr(wa), .i_wr_data(wd), .i_wr_be(be),
    .i_rd_en(rd_en), .i_rd_addr(ra), .o_rd_data(o_d[1]), .o_rd_valid(o_v[1]));

  ram_dp_be #(.DATA_W(32), .BYTE_W(8), .ADDR_W(4), .SIZE(12), .RDW_MODE(0), .READ_LAT(1)) u_dut2 (
    .clk(clk), .rst(rst), .i_clr_req(clr), .o_busy(o_b[2]),
    .i_wr_en(wr_en), .i_wr_addr(wa), .i_wr_data(wd), .i_wr_be(be),
    .i_rd_en(rd_en), .i_rd_addr(ra), .o_rd_data(o_d[2]), .o_rd_valid(o_v[2]));

  typedef struct {
    logic        v;
    logic [31:0] d;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  exp_t        sb [3][$];
  vec_t        tbl [$];
  int          lat [3] = '{1, 2, 1};
  int          sz  [3] = '{16, 16, 12};
  int          rem [3];
  logic [31:0] held [3];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, push expectations, clock, then check.
  task automatic step(input logic r_in, input logic c_in, input logic we_in,
                      input logic [3:0] wa_in, input logic [31:0] wd_in, input logic [3:0] be_in,
                      input logic re_in, input logic [3:0] ra_in,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] ex [3];
    exp_t        e;
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    rst = r_in; clr = c_in; wr_en = we_in; wa = wa_in; wd = wd_in; be = be_in;
    rd_en = re_in; ra = ra_in;
    for (int d = 0; d < 3; d++) begin
      if (r_in) begin
        sb[d].delete();
        held[d] = '0;
        rem[d]  = sz[d];
        for (int i = 0; i < lat[d]; i++) begin
          e.v = 1'b0; e.d = '0;
          sb[d].push_back(e);
        end
      end else if (rem[d] > 0) begin
        rem[d]--;
        e.v = 1'b0; e.d = '0;
        sb[d].push_back(e);
      end else begin
        e.v = re_in; e.d = ex[d];
        sb[d].push_back(e);
        if (c_in) rem[d] = sz[d];
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("busy", d, 32'(o_b[d]), 32'(rem[d] > 0));
      if (sb[d].size() >= lat[d]) begin
        e = sb[d].pop_front();
        chk("rd_valid", d, 32'(o_v[d]), 32'(e.v));
        if (e.v) begin
          chk("rd_data", d, o_d[d], e.d);
          held[d] = e.d;
        end else begin
          chk("rd_hold", d, o_d[d], held[d]);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic rd_all(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    step(0, 0, 0, 4'd0, 32'd0, 4'd0, 1, a, e0, e1, e2);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    step(0, 0, 1, a, d, b, 0, 4'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic add(input logic we_i, input logic [3:0] wa_i, input logic [31:0] wd_i, input logic [3:0] be_i,
                     input logic re_i, input logic [3:0] ra_i,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.we = we_i; v.wa = wa_i; v.wd = wd_i; v.be = be_i;
    v.re = re_i; v.ra = ra_i; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wa = '0; ra = '0; wd = '0; be = '0;

    //   we wa     wd            be       re ra     dut0          dut1          dut2
    add(1, 4'd3,  32'hAABBCCDD, 4'b1111, 0, 4'd0,  32'h0,        32'h0,        32'h0);
    add(1, 4'd3,  32'h11223344, 4'b0101, 0, 4'd0,  32'h0,        32'h0,        32'h0);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd3,  32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
    add(1, 4'd5,  32'h12345678, 4'b1111, 0, 4'd0,  32'h0,        32'h0,        32'h0);
    add(1, 4'd5,  32'hFFFFFFFF, 4'b0011, 1, 4'd5,  32'h12345678, 32'h1234FFFF, 32'h12345678);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd5,  32'h1234FFFF, 32'h1234FFFF, 32'h1234FFFF);
    add(1, 4'd9,  32'hCAFEF00D, 4'b1111, 1, 4'd3,  32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
    add(1, 4'd9,  32'h77000000, 4'b1000, 1, 4'd9,  32'hCAFEF00D, 32'h77FEF00D, 32'hCAFEF00D);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd9,  32'h77FEF00D, 32'h77FEF00D, 32'h77FEF00D);
    add(1, 4'd0,  32'hFFFFFFFF, 4'b0000, 1, 4'd0,  32'h0,        32'h0,        32'h0);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd0,  32'h0,        32'h0,        32'h0);
    add(1, 4'd1,  32'h01010101, 4'b1111, 0, 4'd0,  32'h0,        32'h0,        32'h0);
    add(1, 4'd2,  32'h02020202, 4'b1111, 0, 4'd0,  32'h0,        32'h0,        32'h0);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd1,  32'h01010101, 32'h01010101, 32'h01010101);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd2,  32'h02020202, 32'h02020202, 32'h02020202);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd3,  32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
    add(0, 4'd0,  32'h0,        4'b0000, 0, 4'd0,  32'h0,        32'h0,        32'h0);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd9,  32'h77FEF00D, 32'h77FEF00D, 32'h77FEF00D);
    add(0, 4'd0,  32'h0,        4'b0000, 0, 4'd0,  32'h0,        32'h0,        32'h0);
    add(0, 4'd0,  32'h0,        4'b0000, 0, 4'd0,  32'h0,        32'h0,        32'h0);
    add(1, 4'd14, 32'hDEADBEEF, 4'b1111, 1, 4'd14, 32'h0,        32'hDEADBEEF, 32'h0);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd14, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    add(1, 4'd11, 32'h0BADF00D, 4'b1111, 1, 4'd15, 32'h0,        32'h0,        32'h0);
    add(0, 4'd0,  32'h0,        4'b0000, 1, 4'd11, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D);

    // Reset, full clear, then every word reads back zero.
    step(1, 0, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 32'd0, 32'd0, 32'd0);
    idle(16);
    for (int a = 0; a < 16; a++) rd_all(4'(a), 32'h0, 32'h0, 32'h0);
    idle(2);

    for (int i = 0; i < tbl.size(); i++) begin
      step(0, 0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra,
           tbl[i].e0, tbl[i].e1, tbl[i].e2);
    end
    idle(2);

    // Clear during traffic: the write at t lands, later traffic is ignored.
    step(0, 1, 1, 4'd7, 32'hA5A5A5A5, 4'b1111, 0, 4'd0, 32'd0, 32'd0, 32'd0);
    idle(1);
    step(0, 0, 0, 4'd0, 32'd0, 4'd0, 1, 4'd3, 32'd0, 32'd0, 32'd0);
    wr(4'd7, 32'h5A5A5A5A, 4'b1111);
    step(0, 1, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 32'd0, 32'd0, 32'd0);
    idle(12);
    rd_all(4'd7, 32'h0, 32'h0, 32'h0);
    rd_all(4'd3, 32'h0, 32'h0, 32'h0);
    rd_all(4'd9, 32'h0, 32'h0, 32'h0);
    rd_all(4'd14, 32'h0, 32'h0, 32'h0);
    idle(2);

    // Reset in the middle of a clear restarts it from word 0.
    wr(4'd7, 32'h11111111, 4'b1111);
    wr(4'd15, 32'h22222222, 4'b1111);
    rd_all(4'd7, 32'h11111111, 32'h11111111, 32'h11111111);
    rd_all(4'd15, 32'h22222222, 32'h22222222, 32'h0);
    step(0, 1, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 32'd0, 32'd0, 32'd0);
    idle(9);
    step(1, 0, 0, 4'd0, 32'd0, 4'd0, 0, 4'd0, 32'd0, 32'd0, 32'd0);
    idle(16);
    rd_all(4'd7, 32'h0, 32'h0, 32'h0);
    rd_all(4'd15, 32'h0, 32'h0, 32'h0);
    rd_all(4'd14, 32'h0, 32'h0, 32'h0);
    rd_all(4'd0, 32'h0, 32'h0, 32'h0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
Parametrised simple-dual-port synchronous RAM: one write port with byte enables and one independent read port. It is the next generation of the team's single-port 8x8 register-file RAM. Adds configurable width and depth, a selectable read-during-write mode, an optional output pipeline stage, and a sequential clear engine. The clear engine replaces single-cycle whole-array reset so the array maps to block RAM. It sits between datapath producers and consumers as a general scratch/buffer memory.

Parameters:
DATA_W, 32, word width in bits; must be an integer multiple of BYTE_W
BYTE_W, 8, bits per byte-enable lane
ADDR_W, 4, address width
SIZE, 16, number of words; 1 <= SIZE <= 2**ADDR_W
RDW_MODE, 0, same-address read/write in one cycle: 0 = read-first (old data), 1 = write-first (new data)
READ_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
clr_req  input  1  pulse: start sequential clear of the whole array
busy  output  1  high while the clear engine runs; ports ignored
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_be  input  DATA_W/BYTE_W  byte enables; bit k covers wr_data[k*BYTE_W +: BYTE_W]
rd_en  input  1  read strobe
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  read data
rd_valid  output  1  rd_data carries the result of a read issued READ_LAT cycles earlier

Behaviour:
- FSM states: IDLE, CLEAR. Clear pointer clr_ptr is ADDR_W bits wide.
- rst=1 (any state, any cycle): next state CLEAR, clr_ptr=0, rd_data=0, rd_valid=0, pipeline stage=0/invalid. busy reads 1 in the cycle after rst is sampled.
- Reset mid-clear restarts clr_ptr at 0. No partial-clear resume.
- CLEAR: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. In the cycle that clr_ptr==SIZE-1, the final write occurs and next state is IDLE. busy is high for exactly SIZE cycles.
- CLEAR: wr_en, rd_en and clr_req are ignored. No memory write from the write port. rd_valid=0. rd_data holds its value; after rst, that value is 0.
- IDLE with clr_req=1: enter CLEAR next cycle, clr_ptr=0. Any wr_en/rd_en in that same cycle are still serviced normally.
- Write (IDLE, wr_en=1): for each k with wr_be[k]=1, replace lane k of mem[wr_addr]; other lanes unchanged. wr_be all-zero: no change.
- Read (IDLE, rd_en=1), READ_LAT=1: rd_data and rd_valid=1 update on the next edge.
- Read, READ_LAT=2: the array output is registered once more, so data appears one cycle later. rd_valid is pipelined identically.
- No read issued: rd_valid=0 in the corresponding output cycle. rd_data holds its last value and does not change.
- Same-cycle read and write to different addresses: the two ports are independent.
- Same-cycle read and write to the same address:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word, enabled lanes new and the rest old.
- Out-of-range address (>= SIZE, only possible when SIZE < 2**ADDR_W): write dropped. Read returns 0 with rd_valid=1.
- Back-to-back reads: one result per cycle, in order, no bubbles.
- Power-up contents are undefined until the first clear completes. The environment asserts rst before use.

Test Plan:
- Reset/clear: rst for 1 cycle with SIZE=16 -> busy=1 for 16 cycles, then 0. Read of addr 0..15 gives 0x00000000 with rd_valid one cycle after each rd_en.
- Byte enables: write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read addr 3 = 0xAA22CC44.
- Read-during-write: mem[5]=0x12345678; same cycle write 0xFFFFFFFF be=4'b0011 and read addr 5 -> RDW_MODE=0 returns 0x12345678, RDW_MODE=1 returns 0x1234FFFF.
- Latency: READ_LAT=2, reads of addr 1,2,3 in consecutive cycles -> rd_valid high on cycles t+2..t+4 with matching data. A gap in rd_en gives rd_valid=0 and held rd_data.
- Clear during traffic: clr_req at t, with wr_en to addr 7 at t and t+3 -> the t write lands and is then cleared. The t+3 write is ignored, busy=1 for t+1..t+16, and addr 7 reads 0 afterwards.
- Reset mid-clear: rst at clear cycle 9 -> busy stays high for 16 cycles after the reset cycle. All words read 0. Out-of-range read (SIZE=12, addr 14) -> 0 with rd_valid=1.
